ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. Consumes the registered `instr_id`, `rd_addr` and resolved operand values, runs a 32-iteration radix-2 shift-add or restoring-divide sequence, and holds the pipeline with a stall request until the result is ready. Returns a one-cycle `done` pulse with the result and destination register for the EX/MEM register.

---
 rtl/ex_muldiv_unit_pkg.sv | 39 +++
 rtl/ex_muldiv_unit_sign_fix.sv | 13 +
 rtl/ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared instruction-definition constants for the RV32M execute path:
// operand width and the M-extension instr_id encodings used by decode and ID/EX.
package ex_muldiv_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    ID_MUL    = 6'h20,
    ID_MULH   = 6'h21,
    ID_MULHSU = 6'h22,
    ID_MULHU  = 6'h23,
    ID_DIV    = 6'h24,
    ID_DIVU   = 6'h25,
    ID_REM    = 6'h26,
    ID_REMU   = 6'h27
  } instr_id_e;

  function automatic logic op_is_div(input logic [5:0] op);
    return op inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
  endfunction

  function automatic logic op_is_rem(input logic [5:0] op);
    return op inside {ID_REM, ID_REMU};
  endfunction

  // Ops that return the upper half of the 64-bit product.
  function automatic logic op_is_high(input logic [5:0] op);
    return op inside {ID_MULH, ID_MULHSU, ID_MULHU};
  endfunction

  function automatic logic op_rs1_signed(input logic [5:0] op);
    return op inside {ID_MULH, ID_MULHSU, ID_DIV, ID_REM};
  endfunction

  function automatic logic op_rs2_signed(input logic [5:0] op);
    return op inside {ID_MULH, ID_DIV, ID_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Two's-complement conditional negation: magnitude extraction of signed
// operands and sign restoration of the final product/quotient/remainder.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_in,
  input  logic         neg,
  output logic [W-1:0] val_out
);

  assign val_out = neg ? ({W{1'b0}} - val_in) : val_in;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX: radix-2 shift-add multiply and
// restoring divide, 32 iterations, stalling the front end until done.
module ex_muldiv_unit #(
  parameter int XLEN = ex_muldiv_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [5:0]      instr_id_in,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);
  import ex_muldiv_unit_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_p0;
  logic [4:0]          cnt_p0;
  logic [5:0]          op_p0;
  logic                neg_q_p0;
  logic                neg_r_p0;
  logic [XLEN-1:0]     opb_p0;
  logic [XLEN-1:0]     quo_p0;
  logic [XLEN:0]       rem_p0;
  logic [2*XLEN-1:0]   prod_p0;
  logic                vld_p1;
  logic [XLEN-1:0]     res_p1;

  // Operand magnitudes; index 0 is rs1, index 1 is rs2.
  logic [1:0][XLEN-1:0] opnd_raw;
  logic [1:0][XLEN-1:0] opnd_mag;
  logic [1:0]           opnd_neg;

  assign opnd_raw    = {rs2_value, rs1_value};
  assign opnd_neg[0] = op_rs1_signed(instr_id_in) & rs1_value[XLEN-1];
  assign opnd_neg[1] = op_rs2_signed(instr_id_in) & rs2_value[XLEN-1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd_fix
    muldiv_sign_fix #(.W(XLEN)) u_opnd_fix (
      .val_in  (opnd_raw[gi]),
      .neg     (opnd_neg[gi]),
      .val_out (opnd_mag[gi])
    );
  end

  // Divide-by-zero and signed overflow complete without iterating.
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign div_zero = op_is_div(instr_id_in) && (rs2_value == '0);
  assign div_ovf  = ((instr_id_in == ID_DIV) || (instr_id_in == ID_REM)) &&
                    (rs1_value == INT_MIN) && (rs2_value == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_is_rem(instr_id_in) ? rs1_value : '1;
    else if (div_ovf)
      special_res = op_is_rem(instr_id_in) ? '0 : INT_MIN;
  end

  // One multiply step: add multiplicand into the high half when the low bit
  // is set, then shift the whole accumulator right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_nxt;

  assign mul_sum  = {1'b0, prod_p0[2*XLEN-1:XLEN]} +
                    {1'b0, opb_p0 & {XLEN{prod_p0[0]}}};
  assign prod_nxt = {mul_sum, prod_p0[XLEN-1:1]};

  // One restoring-divide step; the extra top bit of the difference flags a
  // trial subtraction that went negative.
  logic [XLEN+1:0] div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign div_shift = {rem_p0, quo_p0[XLEN-1]};
  assign div_diff  = div_shift - {2'b00, opb_p0};
  assign div_ge    = ~div_diff[XLEN+1];
  assign rem_nxt   = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
  assign quo_nxt   = {quo_p0[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] fix_in;
  logic [2*XLEN-1:0] fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    fix_in  = prod_nxt;
    fix_neg = neg_q_p0;
    if (op_is_rem(op_p0)) begin
      fix_in  = {{XLEN{1'b0}}, rem_nxt[XLEN-1:0]};
      fix_neg = neg_r_p0;
    end else if (op_is_div(op_p0)) begin
      fix_in  = {{XLEN{1'b0}}, quo_nxt};
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_res_fix (
    .val_in  (fix_in),
    .neg     (fix_neg),
    .val_out (fix_out)
  );

  assign final_res = op_is_high(op_p0) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

  // ---- iteration / result register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= S_IDLE;
      cnt_p0      <= '0;
      op_p0       <= '0;
      neg_q_p0    <= 1'b0;
      neg_r_p0    <= 1'b0;
      opb_p0      <= '0;
      quo_p0      <= '0;
      rem_p0      <= '0;
      prod_p0     <= '0;
      vld_p1      <= 1'b0;
      res_p1      <= '0;
      rd_addr_out <= '0;
    end else if (flush) begin
      state_p0    <= S_IDLE;
      cnt_p0      <= '0;
      op_p0       <= '0;
      neg_q_p0    <= 1'b0;
      neg_r_p0    <= 1'b0;
      opb_p0      <= '0;
      quo_p0      <= '0;
      rem_p0      <= '0;
      prod_p0     <= '0;
      vld_p1      <= 1'b0;
      res_p1      <= '0;
      rd_addr_out <= '0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          if (start) begin
            op_p0       <= instr_id_in;
            rd_addr_out <= rd_addr_in;
            neg_q_p0    <= opnd_neg[0] ^ opnd_neg[1];
            neg_r_p0    <= opnd_neg[0];
            opb_p0      <= opnd_mag[1];
            quo_p0      <= opnd_mag[0];
            rem_p0      <= '0;
            prod_p0     <= {{XLEN{1'b0}}, opnd_mag[0]};
            cnt_p0      <= '0;
            if (special) begin
              state_p0 <= S_DONE;
              vld_p1   <= 1'b1;
              res_p1   <= special_res;
            end else begin
              state_p0 <= S_RUN;
            end
          end
        end
        S_RUN: begin
          prod_p0 <= prod_nxt;
          rem_p0  <= rem_nxt;
          quo_p0  <= quo_nxt;
          cnt_p0  <= cnt_p0 + 5'd1;
          if (cnt_p0 == 5'd31) begin
            state_p0 <= S_DONE;
            vld_p1   <= 1'b1;
            res_p1   <= final_res;
          end
        end
        S_DONE: begin
          state_p0 <= S_IDLE;
          vld_p1   <= 1'b0;
          res_p1   <= '0;
        end
        default: begin
          state_p0 <= S_IDLE;
          vld_p1   <= 1'b0;
          res_p1   <= '0;
        end
      endcase
    end
  end

  // A squash arriving in the DONE cycle must kill the result seen by EX/MEM.
  assign done      = vld_p1 & ~flush;
  assign result    = done ? res_p1 : '0;
  assign busy      = (state_p0 != S_IDLE);
  assign stall_req = ((state_p0 == S_IDLE) & start & ~flush) | (state_p0 == S_RUN);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a vector table of RV32M ops with
// hand-computed results, plus flush, mid-operation reset and held-start sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  instr_id_in = '0;
  logic [31:0] rs1_value = '0;
  logic [31:0] rs2_value = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr_id_in (instr_id_in),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
    .rd_addr_in  (rd_addr_in),
    .flush       (flush),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .rd_addr_out (rd_addr_out)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [4:0]  rd;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op (start dropped after the accepting edge) and wait up to 40
  // edges for done; counts edges to done and cycles with stall_req high.
  task automatic run_op(input vec_t v, output int lat, output int stalls,
                        output logic [31:0] res, output logic [4:0] rdo, output logic got);
    @(negedge clk);
    instr_id_in = v.op;
    rs1_value   = v.a;
    rs2_value   = v.b;
    rd_addr_in  = v.rd;
    start       = 1'b1;
    lat = 0; stalls = 0; got = 1'b0; res = '0; rdo = '0;
    while (!got && lat < 40) begin
      #1;
      if (stall_req) stalls++;
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        res = result;
        rdo = rd_addr_out;
      end
    end
  endtask

  initial begin
    int          lat;
    int          stalls;
    int          cnt;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        got;

    vecs[0]  = '{ID_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd1,  33};
    vecs[1]  = '{ID_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd2,  33};
    vecs[2]  = '{ID_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd3,  33};
    vecs[3]  = '{ID_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5'd4,  33};
    vecs[4]  = '{ID_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 5'd5,  33};
    vecs[5]  = '{ID_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 5'd6,  33};
    vecs[6]  = '{ID_DIVU,   32'd100,       32'd7,         32'd14,        5'd7,  33};
    vecs[7]  = '{ID_REMU,   32'd100,       32'd7,         32'd2,         5'd8,  33};
    vecs[8]  = '{ID_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 5'd9,  1};
    vecs[9]  = '{ID_REM,    32'd5,         32'd0,         32'd5,         5'd10, 1};
    vecs[10] = '{ID_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11, 1};
    vecs[11] = '{ID_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd12, 1};
    vecs[12] = '{ID_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 5'd13, 33};
    vecs[13] = '{ID_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd14, 33};
    vecs[14] = '{ID_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 5'd15, 33};
    vecs[15] = '{ID_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 5'd16, 33};
    vecs[16] = '{ID_REMU,   32'h8000_0000, 32'd0,         32'h8000_0000, 5'd31, 1};
    vecs[17] = '{ID_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'd17, 33};
    vecs[18] = '{ID_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd18, 33};
    vecs[19] = '{ID_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd19, 33};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'b0, busy},      32'd0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_done",  {31'b0, done},      32'd0);
    chk("rst_result", result,            32'd0);
    chk("rst_rd",    {27'b0, rd_addr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], lat, stalls, res, rdo, got);
      chk($sformatf("v%0d_done_seen", i), {31'b0, got}, 32'd1);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("v%0d_rd", i), {27'b0, rdo}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].exp_lat);
      chk($sformatf("v%0d_stall_in_done", i), {31'b0, stall_req}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_cleared", i), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_result_cleared", i), result, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
    end

    // Flush at cycle 10 of a DIV
    @(negedge clk);
    instr_id_in = ID_DIV; rs1_value = 32'd100; rs2_value = 32'd7; rd_addr_in = 5'd21;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_cycle_done", {31'b0, done}, 32'd0);
    chk("flush_cycle_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle_busy",  {31'b0, busy},      32'd0);
    chk("flush_idle_stall", {31'b0, stall_req}, 32'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("flush_no_done", cnt, 32'd0);
    run_op(vecs[6], lat, stalls, res, rdo, got);
    chk("post_flush_result",  res, 32'd14);
    chk("post_flush_latency", lat, 32'd33);
    @(posedge clk);
    #1;

    // Asynchronous reset at cycle 20 of a MUL
    @(negedge clk);
    instr_id_in = ID_MUL; rs1_value = 32'd7; rs2_value = 32'hFFFF_FFFD; rd_addr_in = 5'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy",   {31'b0, busy},        32'd0);
    chk("async_rst_stall",  {31'b0, stall_req},   32'd0);
    chk("async_rst_done",   {31'b0, done},        32'd0);
    chk("async_rst_result", result,               32'd0);
    chk("async_rst_rd",     {27'b0, rd_addr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("rst_no_done", cnt, 32'd0);

    // start held high through the whole operation
    @(negedge clk);
    instr_id_in = ID_MUL; rs1_value = 32'd7; rs2_value = 32'hFFFF_FFFD; rd_addr_in = 5'd20;
    start = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
    end
    chk("held_latency", lat, 32'd33);
    chk("held_result", result, 32'hFFFF_FFEB);
    chk("held_rd", {27'b0, rd_addr_out}, 32'd20);
    @(posedge clk);
    #1;
    chk("held_idle_busy",    {31'b0, busy},      32'd0);
    chk("held_idle_stall",   {31'b0, stall_req}, 32'd1);
    chk("held_idle_no_done", {31'b0, done},      32'd0);
    start = 1'b0;
    #1;
    chk("held_release_stall", {31'b0, stall_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
